// File: rtl/bt_echo_fifo.sv
// UART echo buffer: received words go through a DEPTH-entry circular FIFO back to the transmitter.
// Optional rx/tx word counters are enabled with the BT_ECHO_CNT_EN macro.
//
// state  | meaning
// R_IDLE | waiting for rxrdy
// R_RD   | oen low, data_rx captured on the exit edge
// R_END  | oen high, recovery cycle before the next read
// T_IDLE | waiting for a buffered word and txrdy
// T_WR   | wr low, data_tx holds the popped word
// T_END  | wr high, data_tx still held
module bt_echo_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rxrdy,
   input  logic                     txrdy,
   input  logic [DATA_W-1:0]        data_rx,
   output logic [DATA_W-1:0]        data_tx,
   output logic                     wr,
   output logic                     oen,
   input  logic                     ovf_clr,
   output logic                     ovf,
   output logic [$clog2(DEPTH):0]   level
`ifdef BT_ECHO_CNT_EN
   ,
   output logic [15:0]              rx_cnt,
   output logic [15:0]              tx_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;
   localparam logic [AW:0] LVL_FULL = DEPTH[AW:0];

   typedef enum logic [1:0] {R_IDLE, R_RD, R_END} rx_state_t;
   typedef enum logic [1:0] {T_IDLE, T_WR, T_END} tx_state_t;

   rx_state_t rx_state, rx_next;
   tx_state_t tx_state, tx_next;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW:0]       wr_ptr, rd_ptr;
   logic              run;
   logic              push, pop, full, accept, drop;

   // Holds both FSMs off for the first edge after reset release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) run <= 1'b0;
      else     run <= 1'b1;
   end

   assign level  = wr_ptr - rd_ptr;
   assign full   = (level == LVL_FULL);
   assign push   = (rx_state == R_RD);
   assign pop    = run && (tx_state == T_IDLE) && txrdy && (level != '0);
   assign accept = push && (!full || pop);
   assign drop   = push && full && !pop;

   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         R_IDLE:  if (run && rxrdy) rx_next = R_RD;
         R_RD:    rx_next = R_END;
         R_END:   rx_next = R_IDLE;
         default: rx_next = R_IDLE;
      endcase
   end

   always_comb begin
      tx_next = tx_state;
      case (tx_state)
         T_IDLE:  if (pop) tx_next = T_WR;
         T_WR:    tx_next = T_END;
         T_END:   tx_next = T_IDLE;
         default: tx_next = T_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state <= R_IDLE;
         tx_state <= T_IDLE;
         oen      <= 1'b1;
         wr       <= 1'b1;
      end else begin
         rx_state <= rx_next;
         tx_state <= tx_next;
         oen      <= (rx_next != R_RD);
         wr       <= (tx_next != T_WR);
      end
   end

   // Pointers carry one extra bit so full and empty are distinguishable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr[AW-1:0]] <= data_rx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)      data_tx <= '0;
      else if (pop) data_tx <= mem[rd_ptr[AW-1:0]];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          ovf <= 1'b0;
      else if (drop)    ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
   end

`ifdef BT_ECHO_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_cnt <= '0;
         tx_cnt <= '0;
      end else begin
         if (accept) rx_cnt <= rx_cnt + 16'd1;
         if (pop)    tx_cnt <= tx_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_bt_echo_fifo.sv
// Directed bench for bt_echo_fifo (DEPTH=16, DATA_W=8); counter checks run when BT_ECHO_CNT_EN is defined.
module tb_bt_echo_fifo;

   logic       clk, rst, rxrdy, txrdy, ovf_clr;
   logic [7:0] data_rx, data_tx;
   logic       wr, oen, ovf;
   logic [4:0] level;
`ifdef BT_ECHO_CNT_EN
   logic [15:0] rx_cnt, tx_cnt;
`endif

   int errors = 0;
   int checks = 0;
   int oen_n = 0;
   int wr_n  = 0;
   logic [7:0] tx_log[$];
   int o0, w0;

   bt_echo_fifo #(.DATA_W(8), .DEPTH(16)) dut (
      .clk(clk), .rst(rst), .rxrdy(rxrdy), .txrdy(txrdy),
      .data_rx(data_rx), .data_tx(data_tx), .wr(wr), .oen(oen),
      .ovf_clr(ovf_clr), .ovf(ovf), .level(level)
`ifdef BT_ECHO_CNT_EN
      , .rx_cnt(rx_cnt), .tx_cnt(tx_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Strobe cycles and transmitted words, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (!oen) oen_n++;
         if (!wr) begin
            wr_n++;
            tx_log.push_back(data_tx);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic rx_word(input logic [7:0] d);
      data_rx = d;
      rxrdy   = 1'b1;
      cyc(1);
      rxrdy   = 1'b0;
      cyc(2);
   endtask

   task automatic check_log(input string tag, input int base, input int first, input int n);
      logic [7:0] v;
      for (int i = 0; i < n; i++) begin
         if (base + i < tx_log.size()) v = tx_log[base + i];
         else v = 'x;
         chk($sformatf("%s[%0d]", tag, i), {24'd0, v}, first + i);
      end
   endtask

   initial begin
      rst = 1'b1; rxrdy = 1'b0; txrdy = 1'b0; ovf_clr = 1'b0; data_rx = '0;
      cyc(3);
      chk("rst_wr", wr, 1);
      chk("rst_oen", oen, 1);
      chk("rst_data_tx", data_tx, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_level", level, 0);

      // single echo, requested right at reset release
      rst = 1'b0; data_rx = 8'h5A; rxrdy = 1'b1; txrdy = 1'b1;
      cyc(1);
      chk("oen_first_edge", oen, 1);
      chk("wr_first_edge", wr, 1);
      cyc(1);
      chk("oen_second_edge", oen, 0);
      rxrdy = 1'b0;
      cyc(1);
      chk("echo_oen_end", oen, 1);
      chk("echo_level_push", level, 1);
      cyc(1);
      chk("echo_wr_low", wr, 0);
      chk("echo_data_tx", data_tx, 8'h5A);
      chk("echo_level_pop", level, 0);
      cyc(3);
      chk("echo_wr_end", wr, 1);
      chk("echo_oen_cycles", oen_n, 1);
      chk("echo_wr_cycles", wr_n, 1);
      check_log("echo_log", 0, 8'h5A, 1);

      // fill to full, then one dropped word
      txrdy = 1'b0;
      o0 = oen_n;
      for (int i = 0; i < 16; i++) rx_word(8'(i));
      chk("fill_level16", level, 16);
      chk("fill_ovf_before_drop", ovf, 0);
      rx_word(8'h10);
      chk("fill_level_after_drop", level, 16);
      chk("fill_ovf_set", ovf, 1);
      chk("fill_oen_cycles", oen_n - o0, 17);
      chk("fill_no_tx", wr_n, 1);

      // ovf_clr alone, then coincident with a drop
      ovf_clr = 1'b1; cyc(1); ovf_clr = 1'b0;
      chk("ovf_clr_plain", ovf, 0);
      data_rx = 8'h77; rxrdy = 1'b1;
      cyc(1);
      rxrdy = 1'b0; ovf_clr = 1'b1;
      cyc(1);
      ovf_clr = 1'b0;
      chk("ovf_set_wins", ovf, 1);
      chk("ovf_drop_level", level, 16);
      cyc(1);
      ovf_clr = 1'b1; cyc(1); ovf_clr = 1'b0;
      chk("ovf_clr_again", ovf, 0);

      // drain in arrival order; dropped words never appear
      w0 = wr_n;
      txrdy = 1'b1;
      cyc(60);
      chk("drain_level", level, 0);
      chk("drain_count", wr_n - w0, 16);
      check_log("drain_order", w0, 0, 16);
      cyc(10);
      chk("empty_no_pop", wr_n - w0, 16);
      txrdy = 1'b0;

      // push and pop on the same edge at level 3
      w0 = wr_n;
      rx_word(8'h31); rx_word(8'h32); rx_word(8'h33);
      chk("sim3_level_pre", level, 3);
      data_rx = 8'h34; rxrdy = 1'b1;
      cyc(1);
      rxrdy = 1'b0; txrdy = 1'b1;
      cyc(1);
      chk("sim3_level", level, 3);
      chk("sim3_wr", wr, 0);
      chk("sim3_data_tx", data_tx, 8'h31);
      txrdy = 1'b0;
      cyc(4);
      chk("sim3_level_hold", level, 3);
      txrdy = 1'b1;
      cyc(15);
      chk("sim3_level_drained", level, 0);
      check_log("sim3_order", w0, 8'h31, 4);
      txrdy = 1'b0;

      // push and pop on the same edge while full: no drop
      w0 = wr_n;
      for (int i = 0; i < 16; i++) rx_word(8'(8'h40 + i));
      chk("full_sim_level_pre", level, 16);
      data_rx = 8'h50; rxrdy = 1'b1;
      cyc(1);
      rxrdy = 1'b0; txrdy = 1'b1;
      cyc(1);
      chk("full_sim_level", level, 16);
      chk("full_sim_ovf", ovf, 0);
      chk("full_sim_data_tx", data_tx, 8'h40);
      cyc(70);
      chk("full_sim_drained", level, 0);
      chk("full_sim_count", wr_n - w0, 17);
      check_log("full_sim_order", w0, 8'h40, 17);
      txrdy = 1'b0;

      // asynchronous reset while wr is low
      rx_word(8'h91); rx_word(8'h92);
      txrdy = 1'b1;
      for (int k = 0; k < 20; k++) begin
         cyc(1);
         if (wr === 1'b0) break;
      end
      chk("rstmid_wr_low_seen", wr, 0);
      chk("rstmid_level_before", level, 1);
      rst = 1'b1;
      #1;
      chk("rstmid_wr", wr, 1);
      chk("rstmid_level", level, 0);
      chk("rstmid_data_tx", data_tx, 0);
      chk("rstmid_oen", oen, 1);
      txrdy = 1'b0;
      cyc(2);
      rst = 1'b0;
      cyc(2);

`ifdef BT_ECHO_CNT_EN
      txrdy = 1'b1;
      for (int i = 0; i < 5; i++) rx_word(8'(8'hC0 + i));
      cyc(10);
      chk("cnt_rx5", rx_cnt, 5);
      chk("cnt_tx5", tx_cnt, 5);
      txrdy = 1'b0;
      for (int i = 0; i < 16; i++) rx_word(8'(i));
      chk("cnt_rx_full", rx_cnt, 21);
      rx_word(8'hEE);
      chk("cnt_rx_drop", rx_cnt, 21);
      chk("cnt_tx_hold", tx_cnt, 5);
      chk("cnt_ovf", ovf, 1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bt_echo_fifo.md
BT_ECHO_FIFO -- requirements
Module: bt_echo_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of the UART data word.
REQ-002 SHALL have parameter DEPTH, default 16: FIFO entries; a power of 2, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port rxrdy, input, 1 bit: UART receive byte available.
REQ-006 SHALL have port txrdy, input, 1 bit: UART transmitter accepts a byte.
REQ-007 SHALL have port data_rx, input, DATA_W bits: UART receive data.
REQ-008 SHALL have port data_tx, output, DATA_W bits, registered: UART transmit data.
REQ-009 SHALL have port wr, output, 1 bit, registered: active-low UART write strobe.
REQ-010 SHALL have port oen, output, 1 bit, registered: active-low UART read strobe.
REQ-011 SHALL have port ovf_clr, input, 1 bit: one-cycle pulse that clears ovf.
REQ-012 SHALL have port ovf, output, 1 bit: sticky flag, set when a byte is dropped because the FIFO is full.
REQ-013 SHALL have port level, output, $clog2(DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-014 SHALL buffer received words in a DEPTH-entry circular FIFO and echo them to the transmitter in arrival order.
REQ-015 SHALL run the RX FSM (R_IDLE, R_RD, R_END) and TX FSM (T_IDLE, T_WR, T_END) independently and concurrently.
REQ-016 SHALL move the RX FSM from R_IDLE to R_RD when rxrdy=1; otherwise it stays in R_IDLE.
REQ-017 SHALL drive oen=0 for exactly the one cycle the RX FSM is in R_RD.
REQ-018 SHALL sample data_rx on the edge leaving R_RD and push it if level<DEPTH.
REQ-019 SHALL move the RX FSM R_RD -> R_END -> R_IDLE unconditionally, with oen=1 in R_END; one received word costs 3 cycles minimum.
REQ-020 SHALL, when level==DEPTH at the push edge, still complete the oen pulse, discard the word and set ovf.
REQ-021 SHALL move the TX FSM from T_IDLE to T_WR when level>0 and txrdy=1, loading data_tx from the FIFO head and advancing the read pointer on that edge.
REQ-022 SHALL drive wr=0 for exactly the one cycle the TX FSM is in T_WR, with data_tx stable from T_WR through T_END.
REQ-023 SHALL move the TX FSM T_WR -> T_END -> T_IDLE unconditionally, with wr=1 in T_END.
REQ-024 SHALL leave level unchanged when a push and a pop occur on the same edge.
REQ-025 SHALL allow a push and a pop on the same edge when level==DEPTH; the pop frees space, so no drop occurs.
REQ-026 SHALL wrap both FIFO pointers modulo DEPTH with no extra logic.
REQ-027 SHALL never pop when level==0, whatever txrdy is.
REQ-028 SHALL clear ovf on ovf_clr=1; when a drop occurs on the same edge, the set wins and ovf=1.
REQ-029 SHALL drive level combinationally from the registered pointers or counter, with no added latency.

Reset
REQ-030 SHALL, while rst=1, force: wr=1, oen=1, data_tx=0, ovf=0, level=0, both pointers 0, both FSMs idle.
REQ-031 SHALL apply rst mid-transfer immediately; a strobe in progress terminates at once and buffered words are lost.
REQ-032 SHALL start the first possible oen or wr pulse no earlier than the second rising edge after rst deasserts.

Configuration
REQ-033 SHALL, with macro BT_ECHO_CNT_EN defined, add outputs rx_cnt and tx_cnt, 16 bits each, reset to 0. rx_cnt increments on every accepted push; tx_cnt increments on every pop; both wrap at 0xFFFF.
REQ-034 SHALL, without BT_ECHO_CNT_EN, omit the rx_cnt and tx_cnt ports and their logic entirely.

Verification
REQ-035 SHALL cover single echo: rxrdy pulse with data_rx=0x5A, txrdy=1 -> one oen pulse; then one wr pulse with data_tx=0x5A; level returns to 0.
REQ-036 SHALL cover fill: txrdy=0, DEPTH=16, 17 rxrdy events with data 0x00..0x10 -> level=16, ovf=1, 17 oen pulses; then txrdy=1 -> tx order 0x00..0x0F and 0x10 is never sent.
REQ-037 SHALL cover ovf_clr: ovf_clr pulse with no drop -> ovf=0; ovf_clr coincident with a drop edge -> ovf=1.
REQ-038 SHALL cover simultaneous operation: level=3, push and pop on the same edge -> level stays 3 and data ordering is preserved.
REQ-039 SHALL cover reset mid-operation: rst asserted while wr=0 -> wr=1, level=0, data_tx=0 asynchronously, before the next clock edge.
REQ-040 SHALL cover the counter option: with BT_ECHO_CNT_EN, 5 echoes -> rx_cnt=5, tx_cnt=5; with the FIFO full, a dropped word leaves rx_cnt unchanged.
